ib_lut_page_loader: RTL and testbench
=====================================

# ib_lut_page_loader

Write-side loader for the 3-bit IB LUT memory bank. It accepts packed LUT words from a valid/ready stream and unpacks each word into single-entry writes. For each write it drives the LUT RAM's write address, write data and write enable, one entry per cycle, starting at page 0. It signals completion when all PAGE_NUM entries have been written. Optionally, it then reads the bank back through the asynchronous read port and checks a checksum.

## Interface
- QUAN_SIZE, 3, bits per LUT entry
- PAGE_NUM, 32, LUT entries per bank; must be a multiple of ENTRY_PER_WORD
- ADDR_BITWIDTH, 5, LUT address width (log2 PAGE_NUM)
- ENTRY_PER_WORD, 4, entries packed per input word
- write_clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  begin a load; honoured only in IDLE
- s_data_i  input  QUAN_SIZE*ENTRY_PER_WORD  packed word; entry j at bits [j*QUAN_SIZE +: QUAN_SIZE]
- s_valid_i  input  1  word valid
- s_ready_o  output  1  loader can accept word
- lut_write_addr_o  output  ADDR_BITWIDTH  LUT write address
- lut_write_data_o  output  QUAN_SIZE  LUT write data
- lut_we_o  output  1  LUT write enable
- lut_read_addr_o  output  ADDR_BITWIDTH  LUT read address (readback)
- lut_read_page_i  input  QUAN_SIZE  LUT async read data
- busy_o  output  1  high outside IDLE
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  readback checksum mismatch; held until next accepted start

## Operation
- States: IDLE, LOAD, VERIFY (macro only), DONE.
- IDLE: start_i=1 moves to LOAD. The write address counter is cleared, the unpack buffer is emptied, the checksum is cleared and err_o is cleared.
- LOAD, handshake:
  - A transfer occurs when s_valid_i && s_ready_o at a rising edge.
  - s_ready_o = (buffer empty OR last buffered entry on outputs this cycle) AND words remaining > 0.
- LOAD, unpack:
  - A buffered word emits entry 0..ENTRY_PER_WORD-1 in order, one per cycle, with lut_we_o=1.
  - lut_write_addr_o increments by 1 after each write.
  - lut_write_data_o is the current entry slice.
  - With the buffer empty, lut_we_o=0 and address and data hold.
- Checksum: an 8-bit modulo-256 sum of all written entries, zero-extended.
- Completion:
  - The PAGE_NUM-th write has lut_write_addr_o=PAGE_NUM-1.
  - After it, the block goes to VERIFY if the macro is compiled in, otherwise to DONE.
  - The address never wraps, and s_ready_o stays low once PAGE_NUM/ENTRY_PER_WORD words have been accepted.
- VERIFY:
  - lut_read_addr_o steps 0..PAGE_NUM-1, one per cycle.
  - lut_read_page_i is summed in the same cycle.
  - After address PAGE_NUM-1, err_o is set if the read sum differs from the write checksum, and the state goes to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- start_i in any state other than IDLE is ignored. s_valid_i outside LOAD is ignored, and s_ready_o=0 there.
- Reset mid-operation:
  - State returns to IDLE and the buffer is discarded.
  - No done_o is asserted.
  - Partial LUT contents remain in the RAM, since reset does not clear the memory.

## Timing
- Reset values: s_ready_o=0, lut_we_o=0, lut_write_addr_o=0, lut_write_data_o=0, lut_read_addr_o=0, busy_o=0, done_o=0, err_o=0.
- All outputs are driven from registers (state, buffer, counters); there is no combinational path from s_data_i to any output. The only combinational path from s_valid_i to s_ready_o is none.
- start_i sampled at edge E puts the block in LOAD from cycle E+1, with s_ready_o=1 in that cycle.
- Per-word timing:
  - A word accepted at edge T is written as entries 0..3 in cycles T+1..T+4, with lut_we_o high.
  - The LUT RAM samples each entry at the end of its cycle.
- Back-to-back: s_ready_o=1 in cycle T+4, so with s_valid_i held high, writes are gap-free at 1 entry/cycle.
- Without the macro:
  - Full load of 8 words takes 32 write cycles.
  - done_o is asserted in the cycle after the final write cycle.
  - busy_o falls one cycle after done_o.
- With the macro: VERIFY adds PAGE_NUM cycles between the last write and done_o. err_o is valid in the same cycle as done_o.
- A stalled stream (s_valid_i=0 with the buffer empty) inserts idle cycles with lut_we_o=0. It causes no address skip.

## Configuration
- IB_LUT_LOADER_READBACK_CHECK_EN defined:
  - The VERIFY state, read counter and read checksum are built.
  - lut_read_addr_o is driven and err_o is functional.
- Not defined:
  - LOAD goes directly to DONE.
  - lut_read_addr_o is tied to 0, lut_read_page_i is unused and err_o is tied to 0.
  - Ports are unchanged.

## Test plan
- Reset then start, 8 words with s_valid_i always high, word w has entry j = (4w+j) mod 8: expect 32 consecutive lut_we_o cycles at addresses 0..31 with data = addr mod 8; done_o exactly once; s_ready_o low after the 8th accept.
- Same data with s_valid_i toggled 1-0-1-0 between words: expect identical address/data sequence; lut_we_o=0 on gap cycles; no address skipped.
- start_i pulsed repeatedly during LOAD: expect no restart, address continues monotonically, single done_o.
- rst asserted after the 3rd word is accepted:
  - Next cycle lut_we_o=0, busy_o=0, and done_o is never asserted.
  - A subsequent start reloads from address 0.
- Macro defined, bench RAM model returns written data: expect done_o 32 cycles after the last write, err_o=0.
- Macro defined, bench model corrupts entry 5 (returns 7 instead of 5): expect err_o=1 at done_o, held until the next start.

Source files
------------

// File: rtl/ib_lut_page_loader_if.sv
// Stream-in and LUT write/read bus of the IB LUT page loader.
// slave = loader side, master = producer/RAM side.
interface ib_lut_page_loader_if #(
    parameter int QUAN_SIZE      = 3,
    parameter int ENTRY_PER_WORD = 4,
    parameter int ADDR_BITWIDTH  = 5
);
    logic [QUAN_SIZE*ENTRY_PER_WORD-1:0] s_data_i;
    logic                                s_valid_i;
    logic                                s_ready_o;
    logic [ADDR_BITWIDTH-1:0]            lut_write_addr_o;
    logic [QUAN_SIZE-1:0]                lut_write_data_o;
    logic                                lut_we_o;
    logic [ADDR_BITWIDTH-1:0]            lut_read_addr_o;
    logic [QUAN_SIZE-1:0]                lut_read_page_i;
    logic [1:0]                          dbg_state_o;

    modport slave (
        input  s_data_i, s_valid_i, lut_read_page_i,
        output s_ready_o, lut_write_addr_o, lut_write_data_o, lut_we_o,
               lut_read_addr_o, dbg_state_o
    );

    modport master (
        output s_data_i, s_valid_i, lut_read_page_i,
        input  s_ready_o, lut_write_addr_o, lut_write_data_o, lut_we_o,
               lut_read_addr_o, dbg_state_o
    );
endinterface

// File: rtl/ib_lut_page_loader.sv
// Unpacks streamed LUT words into one-entry-per-cycle LUT RAM writes.
// Optional readback checksum: define IB_LUT_LOADER_READBACK_CHECK_EN.
module ib_lut_page_loader #(
    parameter int QUAN_SIZE      = 3,
    parameter int PAGE_NUM       = 32,
    parameter int ADDR_BITWIDTH  = 5,
    parameter int ENTRY_PER_WORD = 4
) (
    input  logic                       write_clk,
    input  logic                       rst,
    input  logic                       start_i,
    ib_lut_page_loader_if.slave        bus,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);
    localparam int WORD_W = QUAN_SIZE * ENTRY_PER_WORD;
    localparam int WORDS  = PAGE_NUM / ENTRY_PER_WORD;
    localparam int IDX_W  = (ENTRY_PER_WORD > 1) ? $clog2(ENTRY_PER_WORD) : 1;
    localparam int CNT_W  = $clog2(WORDS + 1);
    localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(PAGE_NUM - 1);
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(ENTRY_PER_WORD - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_VERIFY = 2'd2, S_DONE = 2'd3} state_t;
    state_t r_state, w_next;

    logic [WORD_W-1:0]        r_buf;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_we;
    logic [CNT_W-1:0]         r_words_left;
    logic [ADDR_BITWIDTH-1:0] r_wr_addr;
    logic [QUAN_SIZE-1:0]     r_wr_data;
    logic [IDX_W-1:0]         w_idx_next;
    logic [QUAN_SIZE-1:0]     w_next_entry;
    logic                     w_ready;
    logic                     w_accept;
    logic                     w_final_write;

    // Valid/ready: a word transfers on a rising edge where s_valid_i && s_ready_o.
    // Ready depends only on registers, so the producer may hold valid without a loop.
    assign w_ready       = (r_state == S_LOAD) && (!r_we || r_idx == LAST_IDX) && (r_words_left != '0);
    assign w_accept      = bus.s_valid_i && w_ready;
    assign w_final_write = (r_state == S_LOAD) && r_we && (r_wr_addr == LAST_ADDR);
    assign w_idx_next    = r_idx + 1'b1;

    always_comb begin
        w_next_entry = '0;
        for (int j = 0; j < ENTRY_PER_WORD; j++) begin
            if (w_idx_next == IDX_W'(j)) w_next_entry = r_buf[j*QUAN_SIZE +: QUAN_SIZE];
        end
    end

`ifdef IB_LUT_LOADER_READBACK_CHECK_EN
    logic [7:0]               r_cksum;
    logic [7:0]               r_rd_sum;
    logic [7:0]               w_rd_sum_next;
    logic [ADDR_BITWIDTH-1:0] r_rd_addr;
    logic                     r_err;

    assign w_rd_sum_next = r_rd_sum + 8'(bus.lut_read_page_i);
`endif

    always_ff @(posedge write_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_next = S_LOAD;
`ifdef IB_LUT_LOADER_READBACK_CHECK_EN
            S_LOAD:   if (w_final_write) w_next = S_VERIFY;
            S_VERIFY: if (r_rd_addr == LAST_ADDR) w_next = S_DONE;
`else
            S_LOAD:   if (w_final_write) w_next = S_DONE;
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (rst) begin
            r_buf        <= '0;
            r_idx        <= '0;
            r_we         <= 1'b0;
            r_words_left <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else if (r_state == S_IDLE && start_i) begin
            r_idx        <= '0;
            r_we         <= 1'b0;
            r_words_left <= CNT_W'(WORDS);
            r_wr_addr    <= '0;
        end else if (r_state == S_LOAD) begin
            // The last address is held so a full bank never wraps back to 0.
            if (r_we && r_wr_addr != LAST_ADDR) r_wr_addr <= r_wr_addr + 1'b1;
            if (w_accept) begin
                r_buf        <= bus.s_data_i;
                r_wr_data    <= bus.s_data_i[QUAN_SIZE-1:0];
                r_idx        <= '0;
                r_we         <= 1'b1;
                r_words_left <= r_words_left - 1'b1;
            end else if (r_we && r_idx != LAST_IDX) begin
                r_idx     <= w_idx_next;
                r_wr_data <= w_next_entry;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

`ifdef IB_LUT_LOADER_READBACK_CHECK_EN
    always_ff @(posedge write_clk) begin
        if (rst) begin
            r_cksum   <= '0;
            r_rd_sum  <= '0;
            r_rd_addr <= '0;
            r_err     <= 1'b0;
        end else if (r_state == S_IDLE && start_i) begin
            r_cksum   <= '0;
            r_rd_sum  <= '0;
            r_rd_addr <= '0;
            r_err     <= 1'b0;
        end else if (r_state == S_LOAD) begin
            if (r_we) r_cksum <= r_cksum + 8'(r_wr_data);
        end else if (r_state == S_VERIFY) begin
            r_rd_sum <= w_rd_sum_next;
            if (r_rd_addr == LAST_ADDR) r_err <= (w_rd_sum_next != r_cksum);
            else                        r_rd_addr <= r_rd_addr + 1'b1;
        end
    end

    assign bus.lut_read_addr_o = r_rd_addr;
    assign err_o               = r_err;
`else
    logic w_unused_read;
    assign w_unused_read       = ^bus.lut_read_page_i;
    assign bus.lut_read_addr_o = '0;
    assign err_o               = 1'b0;
`endif

    assign bus.s_ready_o        = w_ready;
    assign bus.lut_write_addr_o = r_wr_addr;
    assign bus.lut_write_data_o = r_wr_data;
    assign bus.lut_we_o         = r_we;
    assign bus.dbg_state_o      = r_state;
    assign busy_o               = (r_state != S_IDLE);
    assign done_o               = (r_state == S_DONE);
endmodule

// File: tb/tb_ib_lut_page_loader.sv
// Bench for ib_lut_page_loader: table of full loads, reset corner case, readback check.
module tb_ib_lut_page_loader;
    localparam int Q = 3;
    localparam int P = 32;
    localparam int A = 5;
    localparam int E = 4;
`ifdef IB_LUT_LOADER_READBACK_CHECK_EN
    localparam int EXP_LAT       = P + 1;
    localparam int EXP_READ_ADDR = P - 1;
`else
    localparam int EXP_LAT       = 1;
    localparam int EXP_READ_ADDR = 0;
`endif

    typedef struct {
        int gap_mode;
        bit spam;
        int off;
        int exp_writes;
        bit exp_err;
    } vec_t;

    logic write_clk = 1'b0;
    logic rst       = 1'b1;
    logic start_i   = 1'b0;
    logic busy_o, done_o, err_o;
    bit   corrupt   = 1'b0;

    ib_lut_page_loader_if #(.QUAN_SIZE(Q), .ENTRY_PER_WORD(E), .ADDR_BITWIDTH(A)) bus ();

    ib_lut_page_loader dut (
        .write_clk (write_clk),
        .rst       (rst),
        .start_i   (start_i),
        .bus       (bus.slave),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 write_clk = ~write_clk;

    // LUT RAM model: synchronous write, asynchronous read, optional corruption of entry 5.
    logic [Q-1:0] ram [P];
    always @(posedge write_clk) if (bus.lut_we_o) ram[bus.lut_write_addr_o] <= bus.lut_write_data_o;
    assign bus.lut_read_page_i = (corrupt && bus.lut_read_addr_o == A'(5)) ? 3'd7 : ram[bus.lut_read_addr_o];

    logic [A+Q-1:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;
    logic [A+Q-1:0] e_mon;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [Q-1:0] entry_val(input int w, input int j, input int off);
        return Q'((E * w + j + off) % 8);
    endfunction

    function automatic logic [Q*E-1:0] make_word(input int w, input int off);
        logic [Q*E-1:0] wd;
        wd = '0;
        for (int j = 0; j < E; j++) wd[j*Q +: Q] = entry_val(w, j, off);
        return wd;
    endfunction

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 3));
    endfunction

    // Scoreboard: every write cycle must match the head of the expected queue.
    always @(negedge write_clk) begin
        if (!rst) begin
            if (bus.lut_we_o) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_write: got we=1 addr=%0d data=%0d, expected no write",
                             bus.lut_write_addr_o, bus.lut_write_data_o);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("write_addr", 32'(bus.lut_write_addr_o), 32'(e_mon[A+Q-1:Q]));
                    check("write_data", 32'(bus.lut_write_data_o), 32'(e_mon[Q-1:0]));
                end
            end
            if (done_o) done_cnt++;
        end
    end

    task automatic run_load(input vec_t v);
        int d0, w0, w, guard, gap_left, n;
        int addr_exp;
        d0 = done_cnt;
        w0 = wr_cnt;
        @(negedge write_clk);
        start_i = 1'b1;
        @(negedge write_clk);
        start_i = 1'b0;
        check("ready_after_start", 32'(bus.s_ready_o), 32'd1);
        check("err_after_start", 32'(err_o), 32'd0);
        w = 0; guard = 0; gap_left = 0; addr_exp = 0;
        while (w < P / E && guard < 400) begin
            if (gap_left > 0 && bus.s_ready_o) begin
                bus.s_valid_i = 1'b0;
                gap_left--;
            end else begin
                bus.s_valid_i = 1'b1;
            end
            bus.s_data_i = make_word(w, v.off);
            if (v.spam) start_i = 1'($urandom_range(0, 1));
            if (bus.s_valid_i && bus.s_ready_o) begin
                for (int j = 0; j < E; j++) begin
                    exp_q.push_back({A'(addr_exp), entry_val(w, j, v.off)});
                    addr_exp++;
                end
                w++;
                gap_left = pick_gap(v.gap_mode);
            end
            @(negedge write_clk);
            guard++;
        end
        bus.s_valid_i = 1'b0;
        start_i       = 1'b0;
        check("words_accepted", 32'(w), 32'(P / E));
        check("ready_low_after_last", 32'(bus.s_ready_o), 32'd0);
        n = 1;
        while (!done_o && n < 200) begin
            @(negedge write_clk);
            n++;
        end
        check("done_seen", 32'(done_o), 32'd1);
        check("done_latency", 32'(n), 32'(4 + EXP_LAT));
        check("busy_at_done", 32'(busy_o), 32'd1);
        check("err_at_done", 32'(err_o), 32'(v.exp_err));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("write_addr_held", 32'(bus.lut_write_addr_o), 32'(P - 1));
        check("read_addr_at_done", 32'(bus.lut_read_addr_o), 32'(EXP_READ_ADDR));
        @(negedge write_clk);
        check("done_one_cycle", 32'(done_o), 32'd0);
        check("busy_after_done", 32'(busy_o), 32'd0);
        check("err_held", 32'(err_o), 32'(v.exp_err));
        repeat (2) @(negedge write_clk);
        check("done_count", 32'(done_cnt - d0), 32'd1);
        check("write_count", 32'(wr_cnt - w0), 32'(v.exp_writes));
    endtask

    vec_t vecs[4];
    vec_t vreload;

    initial begin
        vecs[0] = '{gap_mode: 0, spam: 1'b0, off: 0, exp_writes: P, exp_err: 1'b0};
        vecs[1] = '{gap_mode: 1, spam: 1'b0, off: 0, exp_writes: P, exp_err: 1'b0};
        vecs[2] = '{gap_mode: 0, spam: 1'b1, off: 3, exp_writes: P, exp_err: 1'b0};
        vecs[3] = '{gap_mode: 2, spam: 1'b1, off: 5, exp_writes: P, exp_err: 1'b0};
        foreach (ram[i]) ram[i] = '0;
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;

        rst = 1'b1;
        repeat (3) @(negedge write_clk);
        check("rst_ready", 32'(bus.s_ready_o), 32'd0);
        check("rst_we", 32'(bus.lut_we_o), 32'd0);
        check("rst_waddr", 32'(bus.lut_write_addr_o), 32'd0);
        check("rst_wdata", 32'(bus.lut_write_data_o), 32'd0);
        check("rst_raddr", 32'(bus.lut_read_addr_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_state", 32'(bus.dbg_state_o), 32'd0);
        rst = 1'b0;
        @(negedge write_clk);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = make_word(0, 0);
        @(negedge write_clk);
        check("valid_in_idle_ignored", 32'(bus.lut_we_o), 32'd0);
        bus.s_valid_i = 1'b0;

        for (int i = 0; i < 4; i++) run_load(vecs[i]);

        // Reset after the third accepted word, then reload from address 0.
        begin
            int w, guard, d0;
            @(negedge write_clk);
            start_i = 1'b1;
            @(negedge write_clk);
            start_i = 1'b0;
            w = 0; guard = 0;
            while (w < 3 && guard < 100) begin
                bus.s_valid_i = 1'b1;
                bus.s_data_i  = make_word(w, 1);
                if (bus.s_ready_o) begin
                    for (int j = 0; j < E; j++) exp_q.push_back({A'(E * w + j), entry_val(w, j, 1)});
                    w++;
                end
                @(negedge write_clk);
                guard++;
            end
            check("mid_words_accepted", 32'(w), 32'd3);
            #1 rst = 1'b1;
            bus.s_valid_i = 1'b0;
            @(negedge write_clk);
            check("mid_rst_we", 32'(bus.lut_we_o), 32'd0);
            check("mid_rst_busy", 32'(busy_o), 32'd0);
            check("mid_rst_ready", 32'(bus.s_ready_o), 32'd0);
            check("mid_rst_waddr", 32'(bus.lut_write_addr_o), 32'd0);
            exp_q.delete();
            rst = 1'b0;
            d0 = done_cnt;
            repeat (10) @(negedge write_clk);
            check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
            vreload = '{gap_mode: 0, spam: 1'b0, off: 2, exp_writes: P, exp_err: 1'b0};
            run_load(vreload);
        end

`ifdef IB_LUT_LOADER_READBACK_CHECK_EN
        corrupt = 1'b1;
        vreload = '{gap_mode: 0, spam: 1'b0, off: 0, exp_writes: P, exp_err: 1'b1};
        run_load(vreload);
        repeat (5) @(negedge write_clk);
        check("err_held_idle", 32'(err_o), 32'd1);
        corrupt = 1'b0;
        vreload = '{gap_mode: 1, spam: 1'b0, off: 0, exp_writes: P, exp_err: 1'b0};
        run_load(vreload);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
